reg_file_dump_engine: RTL and testbench
=======================================

// Module: reg_file_dump_engine
// PURPOSE
//  Read-side master for reg_file. On a start command it walks a contiguous,
//  wrapping range of registers, using both reg_file read ports to fetch two
//  registers per fetch cycle. It streams each value out over a valid/ready
//  interface with its address and a last flag. Used for debug dump and
//  context save, alongside the normal write port owner.
// PARAMETERS
//  ADDR_WIDTH  3   register address width; NUM_REGS = 1<<ADDR_WIDTH (localparam)
//  REG_WIDTH   32  register data width
// PORTS
//  i_clk           in   1             clock, all state on posedge
//  i_rst_n         in   1             asynchronous active-low reset
//  i_start         in   1             start pulse; sampled only in IDLE
//  i_base_addr     in   ADDR_WIDTH    first register to dump
//  i_count         in   ADDR_WIDTH+1  registers to dump; values >NUM_REGS clamp to NUM_REGS
//  o_busy          out  1             high in every state except IDLE
//  o_done          out  1             one-cycle pulse when a dump completes
//  o_reg_a_addr_r  out  ADDR_WIDTH    to reg_file read port A
//  o_reg_b_addr_r  out  ADDR_WIDTH    to reg_file read port B
//  i_reg_a_val_r   in   REG_WIDTH     from reg_file port A (combinational read)
//  i_reg_b_val_r   in   REG_WIDTH     from reg_file port B (combinational read)
//  o_data          out  REG_WIDTH     streamed register value
//  o_data_addr     out  ADDR_WIDTH    address of o_data
//  o_data_last     out  1             final beat of the dump
//  o_data_valid    out  1             beat valid
//  i_data_ready    in   1             sink accepts beat; transfer = valid & ready
// BEHAVIOUR
//  Reset: state=IDLE. o_busy, o_done, o_data_valid and o_data_last = 0.
//   o_data, o_data_addr and both read addresses = 0. ptr and remaining = 0.
//   Reset mid-dump aborts immediately: no further beats and no o_done.
//  FSM states: IDLE, FETCH, SEND_A, SEND_B, DONE.
//  IDLE: on i_start with clamped count != 0:
//   - latch ptr = i_base_addr and remaining = clamped count
//   - next state is FETCH.
//   On i_start with count == 0: next state is DONE (no beats).
//   i_start in any other state is ignored.
//  FETCH (exactly 1 cycle):
//   - o_reg_a_addr_r = ptr; o_reg_b_addr_r = ptr+1 (mod NUM_REGS).
//   - On the clock edge, i_reg_a_val_r and i_reg_b_val_r are captured into buf_a and buf_b.
//   - Next state is SEND_A.
//  SEND_A: valid=1, data=buf_a, addr=ptr, last=(remaining==1). On transfer:
//   remaining==1 -> DONE, else -> SEND_B.
//  SEND_B: valid=1, data=buf_b, addr=ptr+1, last=(remaining==2). On transfer:
//   - remaining==2 -> DONE.
//   - Otherwise remaining -= 2, ptr += 2 (wraps mod NUM_REGS), next state is FETCH.
//  DONE: o_done=1 for one cycle; next state is IDLE; o_busy stays high here.
//  Read address outputs hold their last value outside FETCH.
//  Valid rule: once valid is high, data, addr and last are stable until transfer.
//   Valid never drops without a transfer, except on reset.
//  Snapshot rule: each value is the reg_file read-port output in its FETCH cycle.
//   - A write in that same cycle is seen, via reg_file write-through.
//   - Later writes are not reflected in beats already fetched.
//  Odd count: the B half of the last pair is fetched but never emitted.
//  Throughput: 2 beats per 3 cycles with ready held high.
// TESTING
//  Bench instantiates reg_file with write port driven by the tb and reads driven by this DUT.
//  1. r[i]=i*0x11, base=0, count=8, ready=1.
//     -> 8 beats: addr 0..7, data 0x00..0x77.
//     -> last only on beat 8; o_done pulses once, 12 cycles after start.
//  2. base=6, count=4 -> addr sequence 6,7,0,1 (wrap); last on addr 1.
//  3. count=3 -> exactly 3 beats (0,1,2); last on addr 2; no addr 3 beat.
//     count=0 -> o_done the cycle after the start edge; valid never rises.
//  4. Ready low for 3 cycles on beat 2.
//     -> valid, data and addr held stable; no dropped or duplicated beats.
//     Random ready 50% -> same 8-beat sequence as test 1.
//  5. Write r5=0xDEAD in the FETCH cycle of pair (4,5) -> beat addr 5 = 0xDEAD.
//     Write r5=0xBEEF one cycle later -> beat still 0xDEAD.
//  6. Assert i_rst_n low during SEND_B.
//     -> valid, busy and last go 0 asynchronously; no o_done.
//     Restart with count=2 -> completes normally.

Source files
------------

// File: rtl/reg_file_dump_engine.sv
// rtl/reg_file_dump_engine.sv - read-side dump master streaming a wrapping register range
// Fetches two registers per FETCH cycle over both reg_file read ports, then emits them as beats.
module reg_file_dump_engine #(
  parameter int ADDR_WIDTH = 3,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_reg_a_addr_r,
  output logic [ADDR_WIDTH-1:0] o_reg_b_addr_r,
  input  logic [REG_WIDTH-1:0]  i_reg_a_val_r,
  input  logic [REG_WIDTH-1:0]  i_reg_b_val_r,
  output logic [REG_WIDTH-1:0]  o_data,
  output logic [ADDR_WIDTH-1:0] o_data_addr,
  output logic                  o_data_last,
  output logic                  o_data_valid,
  input  logic                  i_data_ready
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] TWO       = (ADDR_WIDTH + 1)'(2);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_A,
    SEND_B,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [REG_WIDTH-1:0]  buf_b;
  logic [ADDR_WIDTH:0]   count_clamped;

  assign count_clamped = (i_count > MAX_COUNT) ? MAX_COUNT : i_count;

  // Beat outputs are loaded one state ahead so they are already stable when valid rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      remaining      <= '0;
      buf_b          <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_reg_a_addr_r <= '0;
      o_reg_b_addr_r <= '0;
      o_data         <= '0;
      o_data_addr    <= '0;
      o_data_last    <= 1'b0;
      o_data_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            o_busy <= 1'b1;
            if (count_clamped != '0) begin
              ptr            <= i_base_addr;
              remaining      <= count_clamped;
              o_reg_a_addr_r <= i_base_addr;
              o_reg_b_addr_r <= i_base_addr + ADDR_WIDTH'(1);
              state          <= FETCH;
            end else begin
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end
        FETCH: begin
          buf_b        <= i_reg_b_val_r;
          o_data       <= i_reg_a_val_r;
          o_data_addr  <= ptr;
          o_data_last  <= (remaining == ONE);
          o_data_valid <= 1'b1;
          state        <= SEND_A;
        end
        SEND_A: begin
          if (i_data_ready) begin
            if (remaining == ONE) begin
              o_data_valid <= 1'b0;
              o_data_last  <= 1'b0;
              o_done       <= 1'b1;
              state        <= DONE;
            end else begin
              o_data      <= buf_b;
              o_data_addr <= ptr + ADDR_WIDTH'(1);
              o_data_last <= (remaining == TWO);
              state       <= SEND_B;
            end
          end
        end
        SEND_B: begin
          if (i_data_ready) begin
            o_data_valid <= 1'b0;
            o_data_last  <= 1'b0;
            if (remaining == TWO) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              remaining      <= remaining - TWO;
              ptr            <= ptr + ADDR_WIDTH'(2);
              o_reg_a_addr_r <= ptr + ADDR_WIDTH'(2);
              o_reg_b_addr_r <= ptr + ADDR_WIDTH'(3);
              state          <= FETCH;
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dump_engine.sv
// tb/tb_reg_file_dump_engine.sv - directed bench for reg_file_dump_engine with a write-through reg_file model
module tb_reg_file_dump_engine;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_base_addr = '0;
  logic [3:0]  i_count = '0;
  logic        o_busy, o_done;
  logic [2:0]  o_reg_a_addr_r, o_reg_b_addr_r;
  logic [31:0] reg_a_val, reg_b_val;
  logic [31:0] o_data;
  logic [2:0]  o_data_addr;
  logic        o_data_last, o_data_valid;
  logic        i_data_ready = 1'b1;

  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] regs [8];

  int n_vec = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, valid_cnt = 0, stall_seen = 0, proto_err = 0;
  int d0 = 0, start_cyc = 0;
  logic [2:0]  q_addr [$];
  logic [31:0] q_data [$];
  logic        q_last [$];
  logic        held = 1'b0;
  logic [31:0] h_data;
  logic [2:0]  h_addr;
  logic        h_last;

  reg_file_dump_engine #(.ADDR_WIDTH(3), .REG_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_count(i_count), .o_busy(o_busy), .o_done(o_done),
    .o_reg_a_addr_r(o_reg_a_addr_r), .o_reg_b_addr_r(o_reg_b_addr_r),
    .i_reg_a_val_r(reg_a_val), .i_reg_b_val_r(reg_b_val),
    .o_data(o_data), .o_data_addr(o_data_addr), .o_data_last(o_data_last),
    .o_data_valid(o_data_valid), .i_data_ready(i_data_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  assign reg_a_val = (wr_en && wr_addr == o_reg_a_addr_r) ? wr_data : regs[o_reg_a_addr_r];
  assign reg_b_val = (wr_en && wr_addr == o_reg_b_addr_r) ? wr_data : regs[o_reg_b_addr_r];

  // Sink monitor: ready only changes just after posedge, so negedge values decide the next transfer.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      held = 1'b0;
    end else begin
      if (held && !(o_data_valid && o_data == h_data && o_data_addr == h_addr && o_data_last == h_last))
        proto_err++;
      held   = o_data_valid && !i_data_ready;
      h_data = o_data;
      h_addr = o_data_addr;
      h_last = o_data_last;
      if (o_data_valid) valid_cnt++;
      if (o_data_valid && !i_data_ready) stall_seen++;
      if (o_data_valid && i_data_ready) begin
        q_addr.push_back(o_data_addr);
        q_data.push_back(o_data);
        q_last.push_back(o_data_last);
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_dump(input logic [2:0] base, input logic [3:0] cnt);
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    valid_cnt   = 0;
    stall_seen  = 0;
    d0          = done_cnt;
    i_base_addr = base;
    i_count     = cnt;
    i_start     = 1'b1;
    @(posedge i_clk);
    #1;
    i_start   = 1'b0;
    start_cyc = cyc;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low 3 cycles on beat 2
  task automatic wait_done(input int mode);
    int stalls;
    stalls = 0;
    for (int k = 0; k < 200 && done_cnt == d0; k++) begin
      @(posedge i_clk);
      #1;
      if (mode == 1) i_data_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && q_addr.size() == 1 && stalls < 3) begin
        i_data_ready = 1'b0;
        stalls++;
      end else i_data_ready = 1'b1;
    end
    i_data_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic check_seq(input string tag, input logic [2:0] base, input int n,
                           input int ovr_addr, input logic [31:0] ovr_data);
    logic [2:0]  a;
    logic [31:0] d;
    chk($sformatf("%s_nbeats", tag), q_addr.size(), n);
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      a = base + 3'(i);
      d = (int'(a) == ovr_addr) ? ovr_data : 32'(a) * 32'h11;
      chk($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(a));
      chk($sformatf("%s_data%0d", tag, i), q_data[i], d);
      chk($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 32'(i) * 32'h11;
      @(posedge i_clk);
      #1;
    end
    wr_en = 1'b0;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_valid", 32'(o_data_valid), 0);
    chk("rst_last", 32'(o_data_last), 0);
    chk("rst_data", o_data, 0);
    chk("rst_daddr", 32'(o_data_addr), 0);
    chk("rst_raddr", {26'd0, o_reg_a_addr_r, o_reg_b_addr_r}, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    start_dump(3'd0, 4'd8);
    chk("t1_busy", 32'(o_busy), 1);
    wait_done(0);
    check_seq("t1", 3'd0, 8, -1, 0);
    chk("t1_done_lat", done_cyc - start_cyc, 12);
    chk("t1_idle", 32'(o_busy), 0);

    start_dump(3'd6, 4'd4);
    wait_done(0);
    check_seq("t2", 3'd6, 4, -1, 0);

    start_dump(3'd0, 4'd3);
    wait_done(0);
    check_seq("t3odd", 3'd0, 3, -1, 0);
    chk("t3odd_done_lat", done_cyc - start_cyc, 5);

    start_dump(3'd2, 4'd0);
    wait_done(0);
    chk("t3zero_done_lat", done_cyc - start_cyc, 0);
    chk("t3zero_valid", valid_cnt, 0);

    start_dump(3'd3, 4'd12);
    wait_done(0);
    check_seq("t3clamp", 3'd3, 8, -1, 0);

    start_dump(3'd0, 4'd8);
    wait_done(2);
    chk("t4stall_cycles", stall_seen, 3);
    check_seq("t4stall", 3'd0, 8, -1, 0);

    start_dump(3'd0, 4'd8);
    wait_done(1);
    check_seq("t4rand", 3'd0, 8, -1, 0);

    start_dump(3'd0, 4'd8);
    repeat (6) @(posedge i_clk);
    #1;
    wr_en   = 1'b1;
    wr_addr = 3'd5;
    wr_data = 32'hDEAD;
    @(posedge i_clk);
    #1;
    wr_data = 32'hBEEF;
    @(posedge i_clk);
    #1;
    wr_en = 1'b0;
    wait_done(0);
    check_seq("t5", 3'd0, 8, 5, 32'hDEAD);

    start_dump(3'd0, 4'd2);
    repeat (2) @(posedge i_clk);
    #1;
    chk("t6_pre_last", 32'(o_data_last), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(o_data_valid), 0);
    chk("t6_busy", 32'(o_busy), 0);
    chk("t6_last", 32'(o_data_last), 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_beats", q_addr.size(), 1);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    start_dump(3'd0, 4'd2);
    wait_done(0);
    check_seq("t6restart", 3'd0, 2, -1, 0);

    chk("protocol_hold", proto_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
